// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel-write path.
//   SCREEN_W / SCREEN_H : visible raster size in pixels.
//   DEF_X_W / DEF_Y_W / DEF_C_W : default coordinate and colour widths.
//   pixel_t : one pixel write {x, y, color} at the default widths.
//   IDLE / LOCKED : arbiter state encodings, wrapped by arb_state_t.
//   rr_next() : round-robin successor of a client index.
package vga_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  typedef struct packed {
    logic [DEF_X_W-1:0] x;
    logic [DEF_Y_W-1:0] y;
    logic [DEF_C_W-1:0] color;
  } pixel_t;

  localparam logic IDLE   = 1'b0;
  localparam logic LOCKED = 1'b1;

  typedef enum logic {
    ST_IDLE   = IDLE,
    ST_LOCKED = LOCKED
  } arb_state_t;

  // Successor of client index cur among n clients, wrapping to 0.
  function automatic int rr_next(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding pixel beats between the arbiter and the
// VGA adapter output register.
//   clk, resetn : clock and asynchronous active-low reset (clears pointers
//                 and occupancy; storage is not cleared)
//   push, din   : write din when push and not full
//   pop         : discard head entry when pop and not empty
//   dout        : current head entry (combinational from storage)
//   full, empty : occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Pixel-write sink in front of the VGA adapter. Sprite drawers push pixel
// beats over valid/ready; one client is locked per sprite burst (released
// on its last beat) in round-robin order. Accepted beats are buffered in
// pixel_fifo and replayed to the adapter as single-cycle writeEn pulses,
// stalling while vga_busy is high.
//   clk, resetn         : clock, asynchronous active-low reset
//   req_valid/req_last  : per-client beat valid and end-of-sprite flag
//   req_x/req_y/req_color : packed per-client pixel, client i at [i*W +: W]
//   req_ready           : per-client accept (valid & ready)
//   vga_busy            : adapter cannot take a write this cycle
//   writeEn, x_out, y_out, color_out : registered pixel write to adapter
//   sprite_done         : one-cycle pulse after a client's last beat is accepted
// Build option CLIP_EN: off-screen beats (x >= SCREEN_W or y >= SCREEN_H)
// are accepted and handshaked normally but never written.
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int N_CLIENTS  = 2,
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int C_W        = DEF_C_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req_valid,
  input  logic [N_CLIENTS-1:0]     req_last,
  input  logic [N_CLIENTS*X_W-1:0] req_x,
  input  logic [N_CLIENTS*Y_W-1:0] req_y,
  input  logic [N_CLIENTS*C_W-1:0] req_color,
  output logic [N_CLIENTS-1:0]     req_ready,
  input  logic                     vga_busy,
  output logic                     writeEn,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [C_W-1:0]           color_out,
  output logic [N_CLIENTS-1:0]     sprite_done
);

  localparam int PW = X_W + Y_W + C_W;
  localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  // Client index k positions after base, wrapping modulo N_CLIENTS.
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_CLIENTS;
    return CW'(s);
  endfunction

`ifdef CLIP_EN
  function automatic logic offscreen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) >= SCREEN_W) || (int'(y) >= SCREEN_H);
  endfunction
`endif

  arb_state_t     state_q;
  arb_state_t     state_d;
  logic [CW-1:0]  gnt_q;
  logic [CW-1:0]  rr_q;
  logic [CW-1:0]  pick;
  logic           pick_vld;
  logic [CW-1:0]  sel;
  logic           grant_act;

  logic           vld_p0;
  logic           last_p0;
  logic [X_W-1:0] x_p0;
  logic [Y_W-1:0] y_p0;
  logic [C_W-1:0] c_p0;
  logic           accept_p0;
  logic           clip_p0;
  logic           push_p0;
  logic [N_CLIENTS-1:0] ready_p0;
  logic [N_CLIENTS-1:0] done_p0;

  logic           fifo_full;
  logic           fifo_empty;
  logic           pop_p0;
  logic [PW-1:0]  fifo_dout;

  // ---- Stage p0: arbitration, client mux and FIFO push ----
  // First valid client at or after rr_q, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (!pick_vld && (rr_idx(rr_q, k) == CW'(i)) && req_valid[i]) begin
          pick_vld = 1'b1;
          pick     = CW'(i);
        end
      end
    end
  end

  // In IDLE the picked client is served in the same cycle (zero-bubble grant).
  assign sel       = (state_q == ST_IDLE) ? pick : gnt_q;
  assign grant_act = (state_q == ST_LOCKED) || pick_vld;

  always_comb begin
    vld_p0  = 1'b0;
    last_p0 = 1'b0;
    x_p0    = '0;
    y_p0    = '0;
    c_p0    = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (sel == CW'(i)) begin
        vld_p0  = req_valid[i];
        last_p0 = req_last[i];
        x_p0    = req_x[i*X_W +: X_W];
        y_p0    = req_y[i*Y_W +: Y_W];
        c_p0    = req_color[i*C_W +: C_W];
      end
    end
  end

  assign accept_p0 = vld_p0 && grant_act && !fifo_full;

`ifdef CLIP_EN
  assign clip_p0 = offscreen(x_p0, y_p0);
`else
  assign clip_p0 = 1'b0;
`endif

  assign push_p0 = accept_p0 && !clip_p0;

  // Ready is gated by resetn so every output reads 0 while reset is held.
  always_comb begin
    ready_p0 = '0;
    done_p0  = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      ready_p0[i] = resetn && grant_act && (sel == CW'(i)) && !fifo_full;
      done_p0[i]  = accept_p0 && last_p0 && (sel == CW'(i));
    end
  end

  assign req_ready = ready_p0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A single-beat sprite accepted in the grant cycle never locks.
        if (pick_vld && !(accept_p0 && last_p0)) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (accept_p0 && last_p0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_q        <= '0;
      sprite_done <= '0;
    end else begin
      state_q     <= state_d;
      sprite_done <= done_p0;
      if (state_q == ST_IDLE && pick_vld) gnt_q <= pick;
      if (accept_p0 && last_p0) rr_q <= CW'(rr_next(int'(sel), N_CLIENTS));
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_p0),
    .din    ({x_p0, y_p0, c_p0}),
    .pop    (pop_p0),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign pop_p0 = !fifo_empty && !vga_busy;

  // ---- Stage p1: registered write to the adapter ----
  // Coordinates hold their last written value between strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      writeEn   <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
    end else begin
      writeEn <= pop_p0;
      if (pop_p0) {x_out, y_out, color_out} <= fifo_dout;
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter (defaults: 2 clients, 4-deep FIFO).
module tb_vga_write_arbiter;
  import vga_pkg::*;

  localparam int N  = 2;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic vga_busy = 1'b0;
  always #5 clk = ~clk;

  logic          vld [N];
  logic          lst [N];
  logic [XW-1:0] cx  [N];
  logic [YW-1:0] cy  [N];
  logic [CW-1:0] cc  [N];

  logic [N-1:0]    req_valid, req_last, req_ready, sprite_done;
  logic [N*XW-1:0] req_x;
  logic [N*YW-1:0] req_y;
  logic [N*CW-1:0] req_color;
  logic            writeEn;
  logic [XW-1:0]   x_out;
  logic [YW-1:0]   y_out;
  logic [CW-1:0]   color_out;

  assign req_valid = {vld[1], vld[0]};
  assign req_last  = {lst[1], lst[0]};
  assign req_x     = {cx[1], cx[0]};
  assign req_y     = {cy[1], cy[0]};
  assign req_color = {cc[1], cc[0]};

  vga_write_arbiter #(
    .N_CLIENTS (N), .X_W (XW), .Y_W (YW), .C_W (CW), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .resetn (resetn),
    .req_valid (req_valid), .req_last (req_last),
    .req_x (req_x), .req_y (req_y), .req_color (req_color),
    .req_ready (req_ready), .vga_busy (vga_busy),
    .writeEn (writeEn), .x_out (x_out), .y_out (y_out), .color_out (color_out),
    .sprite_done (sprite_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt [N];
  int overlap = 0;
  pixel_t wq[$];
  int wr_cyc[$];
  int acc_cl[$];
  int acc_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resetn && writeEn) begin
      wq.push_back({x_out, y_out, color_out});
      wr_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        acc_cl.push_back(i);
        acc_cyc.push_back(cyc);
      end
      if (sprite_done[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
    if (&req_ready) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq.delete();
    wr_cyc.delete();
    acc_cl.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  function automatic pixel_t mkp(input int x, input int y, input int c);
    pixel_t p;
    p.x = x[XW-1:0];
    p.y = y[YW-1:0];
    p.color = c[CW-1:0];
    return p;
  endfunction

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input int cl, input int x, input int y, input int c,
                      input bit last, input string tag);
    int w;
    w = 0;
    vld[cl] = 1'b1;
    lst[cl] = last;
    cx[cl]  = x[XW-1:0];
    cy[cl]  = y[YW-1:0];
    cc[cl]  = c[CW-1:0];
    @(negedge clk);
    while (!req_ready[cl]) begin
      w++;
      if (w > 100) begin
        chk({tag, "_timeout"}, 32'(w), 32'd0);
        break;
      end
      @(negedge clk);
    end
    tick();
    if (last) vld[cl] = 1'b0;
  endtask

  task automatic check_writes(input string tag, input pixel_t exp[$]);
    chk({tag, "_count"}, 32'(wq.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wq.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), 32'(wq[i]), 32'(exp[i]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pixel_t exp[$];
    int d0, d1, w;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; cx[i] = '0; cy[i] = '0; cc[i] = '0;
      done_cnt[i] = 0;
    end

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_x", 32'(x_out), 32'd0);
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_done", 32'(sprite_done), 32'd0);

    // 1: 16-beat sprite from client 0
    tick();
    clear_logs();
    d0 = done_cnt[0];
    exp.delete();
    for (int i = 0; i < 16; i++) begin
      send(0, 50 + i % 4, 60 + i / 4, 5, (i == 15), "t1");
      exp.push_back(mkp(50 + i % 4, 60 + i / 4, 5));
    end
    repeat (10) tick();
    check_writes("t1", exp);
    if (wr_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t1_latency", 32'(wr_cyc[0] - acc_cyc[0]), 32'd2);
    chk("t1_done", 32'(done_cnt[0] - d0), 32'd1);

    // 2: simultaneous requests after reset, back-to-back bursts
    do_reset();
    clear_logs();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    fork
      begin
        for (int i = 0; i < 3; i++) send(0, 10 + i, 20, 1, (i == 2), "t2c0");
      end
      begin
        for (int i = 0; i < 2; i++) send(1, 30 + i, 40, 6, (i == 1), "t2c1");
      end
      begin
        @(negedge clk);
        chk("t2_ready_first", 32'(req_ready), 32'b01);
      end
    join
    repeat (10) tick();
    chk("t2_acc_count", 32'(acc_cl.size()), 32'd5);
    if (acc_cl.size() == 5) begin
      chk("t2_order", {27'd0, 1'(acc_cl[0]), 1'(acc_cl[1]), 1'(acc_cl[2]),
                       1'(acc_cl[3]), 1'(acc_cl[4])}, 32'b00011);
      chk("t2_no_bubble", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
    end
    exp.delete();
    exp.push_back(mkp(10, 20, 1)); exp.push_back(mkp(11, 20, 1));
    exp.push_back(mkp(12, 20, 1)); exp.push_back(mkp(30, 40, 6));
    exp.push_back(mkp(31, 40, 6));
    check_writes("t2", exp);
    if (wr_cyc.size() == 5) chk("t2_wr_back2back", 32'(wr_cyc[4] - wr_cyc[0]), 32'd4);
    chk("t2_done0", 32'(done_cnt[0] - d0), 32'd1);
    chk("t2_done1", 32'(done_cnt[1] - d1), 32'd1);

    // 3: adapter busy for 10 cycles mid-burst
    clear_logs();
    d0 = done_cnt[0];
    exp.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) send(0, 70 + i, 30, i % 8, (i == 11), "t3");
      end
      begin
        w = 0;
        while (acc_cyc.size() < 3 && w < 200) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        #1 vga_busy = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t3_full_count", 32'(dut.u_fifo.count), 32'd4);
        chk("t3_ready_low", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        #1 vga_busy = 1'b0;
      end
    join
    for (int i = 0; i < 12; i++) exp.push_back(mkp(70 + i, 30, i % 8));
    repeat (20) tick();
    check_writes("t3", exp);
    chk("t3_done", 32'(done_cnt[0] - d0), 32'd1);

    // 4: push+pop at count 2, pop at full
    clear_logs();
    vga_busy = 1'b1;
    vld[0] = 1'b1; lst[0] = 1'b0; cx[0] = 8'd1; cy[0] = 7'd2; cc[0] = 3'd1;
    tick();
    cx[0] = 8'd2;
    tick();
    vga_busy = 1'b0; cx[0] = 8'd3;
    @(negedge clk);
    chk("t4_cnt_before", 32'(dut.u_fifo.count), 32'd2);
    chk("t4_ready_cnt2", 32'(req_ready[0]), 32'd1);
    tick();
    vga_busy = 1'b1; cx[0] = 8'd4;
    @(negedge clk);
    chk("t4_cnt_pushpop", 32'(dut.u_fifo.count), 32'd2);
    tick();
    cx[0] = 8'd5;
    tick();
    cx[0] = 8'd6; lst[0] = 1'b1; vga_busy = 1'b0;
    @(negedge clk);
    chk("t4_cnt_full", 32'(dut.u_fifo.count), 32'd4);
    chk("t4_ready_full_pop", 32'(req_ready[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t4_cnt_after_pop", 32'(dut.u_fifo.count), 32'd3);
    chk("t4_ready_after_pop", 32'(req_ready[0]), 32'd1);
    tick();
    vld[0] = 1'b0; lst[0] = 1'b0;
    repeat (10) tick();
    exp.delete();
    for (int i = 1; i <= 6; i++) exp.push_back(mkp(i, 2, 1));
    check_writes("t4", exp);

    // 5: asynchronous reset while locked with 3 beats buffered
    vga_busy = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 90 + i, 5, 7, 1'b0, "t5");
    cx[0] = 8'd93;
    @(negedge clk);
    chk("t5_cnt_pre", 32'(dut.u_fifo.count), 32'd3);
    chk("t5_ready_pre", 32'(req_ready[0]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5_writeEn", 32'(writeEn), 32'd0);
    chk("t5_x", 32'(x_out), 32'd0);
    chk("t5_y", 32'(y_out), 32'd0);
    chk("t5_color", 32'(color_out), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_done", 32'(sprite_done), 32'd0);
    vld[0] = 1'b0;
    vga_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_logs();
    repeat (8) tick();
    chk("t5_no_write", 32'(wq.size()), 32'd0);
    vld[0] = 1'b1; vld[1] = 1'b1; lst[0] = 1'b1; lst[1] = 1'b1;
    @(negedge clk);
    chk("t5_grant0", 32'(req_ready), 32'b01);
    tick();
    vld[0] = 1'b0;
    @(negedge clk);
    chk("t5_grant1_next", 32'(req_ready), 32'b10);
    tick();
    vld[1] = 1'b0; lst[0] = 1'b0; lst[1] = 1'b0;
    repeat (8) tick();

    // 6: beats straddling the right screen edge
    clear_logs();
    d0 = done_cnt[0];
    for (int i = 0; i < 4; i++) send(0, 158 + i, 10, 2, (i == 3), "t6");
    repeat (10) tick();
    exp.delete();
    exp.push_back(mkp(158, 10, 2));
    exp.push_back(mkp(159, 10, 2));
`ifndef CLIP_EN
    exp.push_back(mkp(160, 10, 2));
    exp.push_back(mkp(161, 10, 2));
`endif
    check_writes("t6", exp);
    chk("t6_done", 32'(done_cnt[0] - d0), 32'd1);

    chk("ready_exclusive", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
